// File: rtl/mult_scheduler.sv
// Round-robin arbiter sharing one fixed-point multiplier among NumPorts requesters,
// with operand latching, optional result saturation and a hung-multiplier timeout.
module mult_scheduler #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned DataWidth     = 8,
    parameter bit          Saturate      = 1'b1,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [NumPorts-1:0]           req_i,
    input  logic [NumPorts*DataWidth-1:0] a_i,
    input  logic [NumPorts*DataWidth-1:0] b_i,
    output logic [NumPorts-1:0]           grant_o,
    output logic [NumPorts-1:0]           done_o,
    output logic [DataWidth-1:0]          result_o,
    output logic                          ovf_o,
    output logic                          err_o,
    output logic                          busy_o,
    output logic                          mul_start_o,
    output logic [DataWidth-1:0]          mul_a_o,
    output logic [DataWidth-1:0]          mul_b_o,
    input  logic                          mul_done_i,
    input  logic [DataWidth-1:0]          mul_val_i,
    input  logic                          mul_ovf_i
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NumPorts-1:0]   grant_q, grant_d;
    logic [NumPorts-1:0]   done_q, done_d;
    logic [DataWidth-1:0]  result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  start_q, start_d;
    logic [DataWidth-1:0]  a_q, a_d;
    logic [DataWidth-1:0]  b_q, b_d;

    logic [DataWidth-1:0]  a_arr [NumPorts];
    logic [DataWidth-1:0]  b_arr [NumPorts];
    logic                  win_found;
    logic [PtrW-1:0]       win_idx;
    logic [DataWidth-1:0]  prod_val;

    for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
        assign a_arr[p] = a_i[p*DataWidth +: DataWidth];
        assign b_arr[p] = b_i[p*DataWidth +: DataWidth];
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= int'(NumPorts); i++) begin
            idx = (int'(ptr_q) + i) % int'(NumPorts);
            if (!win_found && req_i[PtrW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(idx);
            end
        end
    end

    // Clamp toward the sign of the true product when the multiplier overflows.
    always_comb begin
        prod_val = mul_val_i;
        if (Saturate && mul_ovf_i) begin
            if (a_q[DataWidth-1] ^ b_q[DataWidth-1]) begin
                prod_val = {1'b1, {(DataWidth-1){1'b0}}};
            end else begin
                prod_val = {1'b0, {(DataWidth-1){1'b1}}};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        busy_d   = busy_q;
        start_d  = 1'b0;
        a_d      = a_q;
        b_d      = b_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    a_d     = a_arr[win_idx];
                    b_d     = b_arr[win_idx];
                    grant_d = NumPorts'(1) << win_idx;
                    ptr_d   = win_idx;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                // A done arriving on the timeout cycle still counts as success.
                if (mul_done_i) begin
                    state_d  = RESP;
                    done_d   = grant_q;
                    result_d = prod_val;
                    ovf_d    = mul_ovf_i;
                    err_d    = 1'b0;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d  = RESP;
                    done_d   = grant_q;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b1;
                end
            end
            RESP: begin
                state_d  = IDLE;
                grant_d  = '0;
                busy_d   = 1'b0;
                result_d = '0;
                ovf_d    = 1'b0;
                err_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves ptr on the last port so port 0 wins first.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            ptr_q    <= PtrW'(NumPorts - 1);
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign mul_start_o = start_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;

endmodule
